burrito_ctrl: RTL

- Multi-cycle R-type sequencer that sits directly upstream of the register bank.
- Fetches 32-bit instruction words, decodes rs/rt/rd/funct, and drives the bank's RR1/RR2/wR/RW plus the ALU operation code.
- Advances the PC and stops on a HALT opcode.
- Instruction memory is external with combinational read (instr is valid in the same cycle ins_addr is driven).

---
 rtl/burrito_pkg.sv | 30 +++
 rtl/burrito_decode.sv | 27 ++
 rtl/burrito_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/burrito_pkg.sv
// Shared types and encodings for the burrito R-type sequencer and its funct decoder.
package burrito_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/burrito_decode.sv
// Combinational funct-to-ALU-code decoder; also reports whether the funct is supported.
module burrito_decode
  import burrito_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       supported
);

  always_comb begin
    alu_op    = ALU_AND;
    supported = 1'b1;
    case (funct)
      FUNCT_ADD: alu_op = ALU_ADD;
      FUNCT_SUB: alu_op = ALU_SUB;
      FUNCT_AND: alu_op = ALU_AND;
      FUNCT_OR:  alu_op = ALU_OR;
      FUNCT_SLT: alu_op = ALU_SLT;
      FUNCT_NOR: alu_op = ALU_NOR;
      default: begin
        alu_op    = ALU_AND;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/burrito_ctrl.sv
// Multi-cycle R-type sequencer: fetches, decodes and drives register-bank addresses,
// write enable and ALU code, advancing the PC until a HALT opcode is seen.
module burrito_ctrl
  import burrito_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      instr,
  output logic [PC_W-1:0]  ins_addr,
  output logic [4:0]       RR1,
  output logic [4:0]       RR2,
  output logic [4:0]       wR,
  output logic             RW,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic              pc_advance;
  logic [31:0]       ir;
  logic              wb_en;
  logic              supp_q;
  logic [3:0]        dec_alu_op;
  logic              dec_supported;
  logic              err_inc;
  logic [5:0]        opcode;
  logic              unused_shamt;

  assign opcode       = ir[31:26];
  assign unused_shamt = ^ir[10:6];

  burrito_decode u_decode (
    .funct     (ir[5:0]),
    .alu_op    (dec_alu_op),
    .supported (dec_supported)
  );

  always_comb begin
    state_next = state;
    pc_advance = 1'b0;
    err_inc    = 1'b0;
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (opcode == OP_HALT) begin
          state_next = HALT;
        end else if (opcode != OP_RTYPE) begin
          err_inc    = 1'b1;
          pc_advance = 1'b1;
          state_next = FETCH;
        end else begin
          err_inc    = !dec_supported;
          state_next = EXEC;
        end
      end
      EXEC:   state_next = WB;
      WB: begin
        pc_advance = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Continuous assign keeps the next-PC path a single, easily observable net.
  assign pc_next = pc_advance ? pc + PC_W'(4) : pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      RR1         <= '0;
      RR2         <= '0;
      wR          <= '0;
      alu_op      <= ALU_AND;
      wb_en       <= 1'b0;
      supp_q      <= 1'b0;
      retired_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH) ir <= instr;
      if (state == DECODE && opcode == OP_RTYPE) begin
        RR1    <= ir[25:21];
        RR2    <= ir[20:16];
        wR     <= ir[15:11];
        alu_op <= dec_alu_op;
        supp_q <= dec_supported;
        wb_en  <= dec_supported && (ir[15:11] != 5'd0);
      end
      if (err_inc && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
      if (state == WB && supp_q) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // A reset landing on the WB cycle must suppress that cycle's write.
  assign RW       = rst_n && wb_en && (state == WB);
  assign ins_addr = pc;
  assign busy     = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
  assign halted   = (state == HALT);

endmodule
